// File: rtl/led_pkg.sv
// Shared LED constants and types used by the chaser and the afterglow PWM stage.
package led_pkg;

  localparam int unsigned N_LED  = 8;
  localparam int unsigned DUTY_W = 4;

  typedef logic [DUTY_W-1:0] level_t;

  localparam level_t      MAX_LEVEL = level_t'((1 << DUTY_W) - 1);
  localparam int unsigned PERIOD    = (1 << DUTY_W) - 1;
  localparam level_t      CNT_LAST  = level_t'(PERIOD - 1);

  // Subtract without wrapping below zero.
  function automatic level_t sat_sub(level_t a, level_t b);
    return (a > b) ? level_t'(a - b) : '0;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level with set/decay, frame-latched duty, registered PWM compare.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              led_bit,
  input  logic [DUTY_W-1:0] cnt,
  input  logic              boundary,
  input  logic              decay,
  output logic              pwm_bit
);

  localparam level_t Step = level_t'(DECAY_STEP);

  level_t level;
  level_t level_next;
  level_t active;

  // A lit chaser bit wins over a coincident decay step.
  always_comb begin
    level_next = level;
    if (led_bit) begin
      level_next = MAX_LEVEL;
    end else if (decay) begin
      level_next = sat_sub(level, Step);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level   <= '0;
      active  <= '0;
      pwm_bit <= 1'b0;
    end else if (enable) begin
      level <= level_next;
      // Latch duty only at frame boundaries so a frame never glitches.
      if (boundary) begin
        active <= level_next;
      end
      pwm_bit <= (cnt < active);
    end else begin
      pwm_bit <= 1'b0;
    end
  end

endmodule

// File: rtl/led_afterglow_pwm.sv
// Afterglow PWM stage: lit chaser LEDs go to full brightness and fade out as a trail.
module led_afterglow_pwm
  import led_pkg::*;
#(
  parameter int unsigned DECAY_DIV  = 16,
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_LED-1:0] led_in,
  output logic [N_LED-1:0] pwm_out,
  output logic             frame_tick
);

  localparam int unsigned       FrameW    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [FrameW-1:0] FrameLast = FrameW'(DECAY_DIV - 1);

  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] cnt_next;
  logic [FrameW-1:0] frame_cnt;
  logic [FrameW-1:0] frame_cnt_next;
  logic              boundary;
  logic              decay;

  always_comb begin
    boundary       = enable && (cnt == CNT_LAST);
    decay          = boundary && (frame_cnt == FrameLast);
    cnt_next       = cnt;
    frame_cnt_next = frame_cnt;
    if (enable) begin
      cnt_next = boundary ? '0 : cnt + 1'b1;
    end
    if (boundary) begin
      frame_cnt_next = decay ? '0 : frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      frame_cnt  <= frame_cnt_next;
      // High exactly while cnt is 0; boundary is already gated by enable.
      frame_tick <= boundary;
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    led_pwm_channel #(
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .led_bit  (led_in[i]),
      .cnt      (cnt),
      .boundary (boundary),
      .decay    (decay),
      .pwm_bit  (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_led_afterglow_pwm.sv
// Directed bench: a default-parameter instance and a fast-decay (DECAY_DIV=1) instance.
module tb_led_afterglow_pwm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       enable_f = 1'b0;
  logic [7:0] led_in = 8'h00;
  logic [7:0] led_f = 8'h00;
  logic [7:0] pwm_out;
  logic [7:0] pwm_f;
  logic       frame_tick;
  logic       tick_f;

  int          checks = 0;
  int          failures = 0;
  int          bad;
  logic [31:0] duty_vec;

  always #5 clock = ~clock;

  led_afterglow_pwm u_dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .led_in     (led_in),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick)
  );

  led_afterglow_pwm #(
    .DECAY_DIV  (1),
    .DECAY_STEP (1)
  ) u_fast (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable_f),
    .led_in     (led_f),
    .pwm_out    (pwm_f),
    .frame_tick (tick_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count high cycles per LED over n cycles; packed 4 bits per LED, LED0 in the low nibble.
  task automatic measure(input bit fast, input int n);
    int         c [8];
    logic [7:0] v;
    for (int i = 0; i < 8; i++) c[i] = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      v = fast ? pwm_f : pwm_out;
      for (int i = 0; i < 8; i++) if (v[i]) c[i]++;
    end
    duty_vec = '0;
    for (int i = 0; i < 8; i++) duty_vec[i*4 +: 4] = 4'(c[i]);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    check("rst_pwm_fast", 32'(pwm_f), 32'h0);

    // First frame latency with LED0 held on
    reset  = 1'b0;
    enable = 1'b1;
    led_in = 8'h01;
    repeat (14) @(negedge clock);
    check("tick_e14", 32'(frame_tick), 32'h0);
    check("pwm_e14", 32'(pwm_out), 32'h0);
    @(negedge clock);
    check("tick_e15", 32'(frame_tick), 32'h1);
    check("pwm_e15", 32'(pwm_out), 32'h0);
    @(negedge clock);
    check("pwm_e16", 32'(pwm_out), 32'h01);
    check("tick_e16", 32'(frame_tick), 32'h0);
    bad = 0;
    repeat (29) begin
      @(negedge clock);
      if (pwm_out !== 8'h01) bad++;
    end
    check("pwm_hold_full", 32'(bad), 32'h0);

    // Chaser-like walk, default pacing (decay at every 16th frame boundary)
    reset = 1'b1;
    @(negedge clock);
    reset  = 1'b0;
    led_in = 8'h03;
    repeat (15) @(negedge clock);
    check("walk_tick", 32'(frame_tick), 32'h1);
    led_in = 8'h0C;
    repeat (15 * 15) @(negedge clock);
    measure(0, 15);
    check("walk_frame16", duty_vec, 32'h0000_FFEE);
    led_in = 8'h30;
    repeat (15 * 15) @(negedge clock);
    measure(0, 15);
    check("walk_frame32", duty_vec, 32'h00FF_EEDD);

    // LED2 set on the same edge as the next decay step
    led_in = 8'h00;
    repeat (14 * 15 + 14) @(negedge clock);
    led_in = 8'h04;
    @(negedge clock);
    led_in = 8'h00;
    check("coll_tick", 32'(frame_tick), 32'h1);
    measure(0, 15);
    check("coll_frame48", duty_vec, 32'h00EE_DFCC);

    // Pause mid-frame at cnt=7, then resume without frame restart
    repeat (7) @(negedge clock);
    enable = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (pwm_out !== 8'h00 || frame_tick !== 1'b0) bad++;
    end
    check("disabled_quiet", 32'(bad), 32'h0);
    enable = 1'b1;
    measure(0, 7);
    check("resume_duty", duty_vec, 32'h0077_6755);
    check("resume_tick_early", 32'(frame_tick), 32'h0);
    @(negedge clock);
    check("resume_tick", 32'(frame_tick), 32'h1);

    // Fast instance: one decay step per frame, saturating at 0
    reset = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    enable_f = 1'b1;
    led_f    = 8'h01;
    repeat (15) @(negedge clock);
    check("fast_tick", 32'(tick_f), 32'h1);
    led_f = 8'h00;
    for (int k = 0; k < 18; k++) begin
      measure(1, 15);
      check($sformatf("fade_%0d", k), duty_vec, (k >= 15) ? 32'h0 : 32'(15 - k));
    end

    // Reset while channel 0 sits at level 9
    led_f = 8'h01;
    repeat (15) @(negedge clock);
    led_f = 8'h00;
    repeat (6 * 15) @(negedge clock);
    measure(1, 5);
    check("fade9_partial", duty_vec, 32'h5);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_pwm", 32'(pwm_f), 32'h0);
    check("midrst_tick", 32'(tick_f), 32'h0);
    bad = 0;
    repeat (14) begin
      @(negedge clock);
      if (tick_f !== 1'b0 || pwm_f !== 8'h00) bad++;
    end
    check("midrst_quiet", 32'(bad), 32'h0);
    @(negedge clock);
    check("midrst_cnt_restart", 32'(tick_f), 32'h1);
    bad = 0;
    repeat (15) begin
      @(negedge clock);
      if (pwm_f !== 8'h00) bad++;
    end
    check("midrst_level_zero", 32'(bad), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_afterglow_pwm.md
# led_afterglow_pwm

Downstream stage of the LED chaser: consumes the chaser's 8-bit `led` pattern and drives the physical LED pins with per-LED PWM, so each LED lit by the chaser stays at full brightness and then fades out as a trail once the chaser moves on. It is built from a free-running PWM period counter, a frame counter that paces the decay, and per-LED brightness registers. Its pins replace the chaser's direct `led` outputs at the top level.

## Interface
- `N_LED`, 8, number of LED channels; must match the chaser width.
- `DUTY_W`, 4, brightness bits; `MAX_LEVEL` = 2^DUTY_W−1 = 15; PWM period `PERIOD` = `MAX_LEVEL` = 15 cycles.
- `DECAY_DIV`, 16, PWM frames between decay steps (≥1).
- `DECAY_STEP`, 1, brightness subtracted per decay step (1..`MAX_LEVEL`).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock on one reset domain.
- `enable`  in  1  1 = run; 0 = freeze all counters and levels and force outputs low.
- `led_in`  in  N_LED  chaser pattern (the chaser's `led` output).
- `pwm_out`  out  N_LED  registered PWM drive to the LED pins.
- `frame_tick`  out  1  registered one-cycle pulse at the start of each PWM frame.

## Operation
- Reset (synchronous, `reset`=1 at an edge): `cnt`=0, `frame_cnt`=0, all `level`=0, all `active`=0, `pwm_out`=0, `frame_tick`=0. Reset mid-frame takes effect at that edge, and the next frame starts from `cnt`=0.
- `cnt` counts 0..`PERIOD`−1 and wraps. A boundary edge is an enabled edge with `cnt`=`PERIOD`−1.
- `frame_cnt` counts 0..`DECAY_DIV`−1 and advances only at boundary edges. A decay edge is a boundary edge with `frame_cnt`=`DECAY_DIV`−1.
- Per LED i, on every enabled edge:
  - If `led_in[i]`=1, `level_next` = `MAX_LEVEL`.
  - Otherwise, on a decay edge, `level_next` = max(`level`−`DECAY_STEP`, 0), with saturating subtraction and no wrap below 0.
  - Otherwise, `level_next` = `level`.
- Simultaneous `led_in[i]`=1 and a decay edge: set wins, so `level_next` = `MAX_LEVEL`.
- At a boundary edge, `active[i]` ← `level_next[i]` (the post-update value). `active` is constant for the whole frame, so the PWM never glitches mid-frame.
- Each enabled edge, `pwm_out[i]` ← (`cnt` < `active[i]`), using the pre-edge `cnt` and `active`.
  - `active`=0: output always low.
  - `active`=15: output always high.
  - Otherwise: exactly L high cycles per 15-cycle frame.
- `frame_tick` ← 1 at each boundary edge and 0 at every other edge, so it is high exactly while `cnt`=0.
- `enable`=0: `cnt`, `frame_cnt`, `level` and `active` hold; `pwm_out` ← 0 and `frame_tick` ← 0 at each such edge. `led_in` is ignored while disabled. When `enable` returns to 1, operation resumes from the held `cnt` with no frame restart.

## Timing
- `led_in` rise to `level` = 15: 1 edge.
- `level` to visible brightness: the next boundary edge, plus 1 edge of `pwm_out` register latency. Worst case is `PERIOD`+1 = 16 edges.
- Decay pacing: one step per `DECAY_DIV`×`PERIOD` = 240 cycles by default. A full fade from 15 to 0 with `DECAY_STEP`=1 takes 15 steps = 3600 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `led_pkg`: `N_LED`, `DUTY_W`, `MAX_LEVEL`, `PERIOD`, and a `level_t` typedef of `DUTY_W` bits. The chaser and the top level import the same package.
- The top holds `cnt`, `frame_cnt`, the boundary/decay strobes and `frame_tick`.
- Sub-module `led_pwm_channel`, generated `N_LED` times. Per channel it holds `level`, `active`, the saturating decrement and the compare register. Inputs: `clock`, `reset`, `enable`, `led_bit`, `cnt`, `boundary`, `decay`. Output: `pwm_bit`.

## Test plan
- Reset, then `led_in`=8'h01 held with `enable`=1 → `frame_tick` high after edge 15; `pwm_out[0]`=1 continuously from edge 16; `pwm_out[7:1]`=0.
- `led_in`=8'h01 for one frame, then 8'h00, with `DECAY_DIV`=1 → channel 0 shows 14, 13, 12… high cycles per successive frame; reaches 0 and stays at 0 with no wrap to 15.
- Chaser-like walk: 8'h03 shifted left one place every 240 cycles with default parameters → trailing LEDs show duty counts decreasing by 1 per 240 cycles; leading LEDs show 15.
- Set/decay collision: `led_in[2]` pulsed high exactly on a decay edge → `level[2]`=15, not 14.
- `enable` dropped mid-frame at `cnt`=7 for 20 cycles → `pwm_out`=0 and `frame_tick`=0 throughout; after re-enable the frame resumes at `cnt`=7 with the same `active` values.
- `reset` asserted mid-fade (`level`=9) → the next edge shows all `level`, `active` and `pwm_out` at 0 and `cnt`=0.
